// File: rtl/sonic_st_rl_timing_adapter.sv
// Avalon-ST ready-latency adapter: IN_RL upstream to RL0 downstream through a credit-managed
// show-ahead skid FIFO; beats arriving without a matching credit are dropped and flagged.
module sonic_st_rl_timing_adapter #(
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 3,
  parameter int IN_RL   = 2,
  parameter int DEPTH   = 8
) (
  input  logic               clk,
  input  logic               reset,
  output logic               in_ready,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_error,
  input  logic               in_startofpacket,
  input  logic               in_endofpacket,
  input  logic [EMPTY_W-1:0] in_empty,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_error,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic [EMPTY_W-1:0] out_empty,
  output logic [15:0]        drop_count,
  output logic               overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = PW + 3;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               error;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } beat_t;

  beat_t         mem [DEPTH];
  beat_t         wr_beat, rd_beat;
  logic [PW-1:0] wr_ptr, rd_ptr, fill;
  logic [3:0]    outstanding;
  logic [SW-1:0] credit_sum;
  logic          legal, push, pop, drop, corrupt, eop_mark;

  // Credits still in flight are counted so the FIFO can absorb every beat the source may send.
  generate
    if (IN_RL == 0) begin : g_no_hist
      assign outstanding = '0;
      assign legal       = in_valid && in_ready;
    end else begin : g_hist
      logic [IN_RL-1:0] rdy_hist;
      always_ff @(posedge clk or posedge reset)
        if (reset) rdy_hist <= '0;
        else       rdy_hist <= IN_RL'({rdy_hist, in_ready});
      always_comb begin
        outstanding = '0;
        for (int i = 0; i < IN_RL; i++) outstanding = outstanding + {3'b000, rdy_hist[i]};
      end
      assign legal = in_valid && rdy_hist[IN_RL-1];
    end
  endgenerate

  assign credit_sum = SW'(fill) + SW'(outstanding);
  assign in_ready   = !reset && (credit_sum < SW'(DEPTH));

  assign push     = legal;
  assign drop     = in_valid && !legal;
  assign pop      = out_valid && out_ready;
  assign eop_mark = corrupt && in_endofpacket;
  assign wr_beat  = '{data: in_data, error: in_error | eop_mark, sop: in_startofpacket,
                      eop: in_endofpacket, empty: in_empty};

  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= wr_beat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
      corrupt    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      fill <= fill + PW'(1);
      else if (!push && pop) fill <= fill - PW'(1);
      // A fresh drop outranks the clearing push so the later EOP still gets marked.
      if (drop) begin
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        overflow <= 1'b1;
        corrupt  <= 1'b1;
      end else if (push && eop_mark) begin
        corrupt <= 1'b0;
      end
    end
  end

  assign out_valid = (fill != '0);
  assign rd_beat   = out_valid ? mem[rd_ptr[AW-1:0]] : '0;

  assign out_data          = rd_beat.data;
  assign out_error         = rd_beat.error;
  assign out_startofpacket = rd_beat.sop;
  assign out_endofpacket   = rd_beat.eop;
  assign out_empty         = rd_beat.empty;
endmodule

// File: tb/tb_sonic_st_rl_timing_adapter.sv
// Bench for the RL adapter: an IN_RL=2/DEPTH=8 instance and an IN_RL=0/DEPTH=2 instance,
// both tracked by a queue-based credit model.
module tb_sonic_st_rl_timing_adapter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
  } beat_t;

  logic        a_in_ready, a_in_valid, a_in_error, a_in_sop, a_in_eop, a_out_ready;
  logic        a_out_valid, a_out_error, a_out_sop, a_out_eop, a_ovf;
  logic [63:0] a_in_data, a_out_data;
  logic [2:0]  a_in_empty, a_out_empty;
  logic [15:0] a_drop;
  logic        b_in_ready, b_in_valid, b_in_error, b_in_sop, b_in_eop, b_out_ready;
  logic        b_out_valid, b_out_error, b_out_sop, b_out_eop, b_ovf;
  logic [63:0] b_in_data, b_out_data;
  logic [2:0]  b_in_empty, b_out_empty;
  logic [15:0] b_drop;

  sonic_st_rl_timing_adapter #(.DATA_W(64), .EMPTY_W(3), .IN_RL(2), .DEPTH(8)) dut_a (
    .clk(clk), .reset(reset), .in_ready(a_in_ready), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_error(a_in_error), .in_startofpacket(a_in_sop), .in_endofpacket(a_in_eop),
    .in_empty(a_in_empty), .out_ready(a_out_ready), .out_valid(a_out_valid),
    .out_data(a_out_data), .out_error(a_out_error), .out_startofpacket(a_out_sop),
    .out_endofpacket(a_out_eop), .out_empty(a_out_empty), .drop_count(a_drop), .overflow(a_ovf));

  sonic_st_rl_timing_adapter #(.DATA_W(64), .EMPTY_W(3), .IN_RL(0), .DEPTH(2)) dut_b (
    .clk(clk), .reset(reset), .in_ready(b_in_ready), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_error(b_in_error), .in_startofpacket(b_in_sop), .in_endofpacket(b_in_eop),
    .in_empty(b_in_empty), .out_ready(b_out_ready), .out_valid(b_out_valid),
    .out_data(b_out_data), .out_error(b_out_error), .out_startofpacket(b_out_sop),
    .out_endofpacket(b_out_eop), .out_empty(b_out_empty), .drop_count(b_drop), .overflow(b_ovf));

  wire [88:0] act_a = {a_in_ready, a_out_valid, a_out_data, a_out_error, a_out_sop, a_out_eop,
                       a_out_empty, a_drop, a_ovf};
  wire [88:0] act_b = {b_in_ready, b_out_valid, b_out_data, b_out_error, b_out_sop, b_out_eop,
                       b_out_empty, b_drop, b_ovf};

  // Reference model: stored beats as queues, granted credits as a queue of ready bits.
  beat_t       qa[$], qb[$];
  logic        ha[$];
  logic [15:0] da, db;
  logic        oa, ob, ca, cb;
  logic [1:0]  obs_a;
  int          checks = 0;
  int          failures = 0;

  function automatic logic m_rdy_a();
    int n = 0;
    foreach (ha[i]) n += int'(ha[i]);
    return !reset && (qa.size() + n < 8);
  endfunction

  function automatic logic m_rdy_b();
    return !reset && (qb.size() < 2);
  endfunction

  function automatic logic [88:0] exp_a();
    beat_t b = '0;
    if (qa.size() != 0) b = qa[0];
    return {m_rdy_a(), qa.size() != 0, b, da, oa};
  endfunction

  function automatic logic [88:0] exp_b();
    beat_t b = '0;
    if (qb.size() != 0) b = qb[0];
    return {m_rdy_b(), qb.size() != 0, b, db, ob};
  endfunction

  task automatic model_reset();
    qa.delete(); qb.delete();
    ha = {1'b0, 1'b0};
    da = '0; db = '0; oa = 0; ob = 0; ca = 0; cb = 0; obs_a = '0;
  endtask

  task automatic tick();
    logic ra, rb, seen;
    beat_t b;
    seen = a_in_ready;
    ra = m_rdy_a();
    rb = m_rdy_b();
    @(posedge clk);
    if (reset) model_reset();
    else begin
      if (a_out_ready && qa.size() != 0) void'(qa.pop_front());
      if (a_in_valid && ha[0]) begin
        b = {a_in_data, a_in_error, a_in_sop, a_in_eop, a_in_empty};
        if (ca && b.eop) begin b.err = 1'b1; ca = 1'b0; end
        qa.push_back(b);
      end else if (a_in_valid) begin
        if (da != 16'hFFFF) da++;
        oa = 1'b1; ca = 1'b1;
      end
      void'(ha.pop_front());
      ha.push_back(ra);
      if (b_out_ready && qb.size() != 0) void'(qb.pop_front());
      if (b_in_valid && rb) begin
        b = {b_in_data, b_in_error, b_in_sop, b_in_eop, b_in_empty};
        if (cb && b.eop) begin b.err = 1'b1; cb = 1'b0; end
        qb.push_back(b);
      end else if (b_in_valid) begin
        if (db != 16'hFFFF) db++;
        ob = 1'b1; cb = 1'b1;
      end
      obs_a = {obs_a[0], seen};
    end
    #1;
  endtask

  // RL=2 source: only sends when the ready it observed two cycles ago was high.
  task automatic drive_a(input logic want, input logic [63:0] d, input logic sop,
                         input logic eop, output logic sent);
    sent = want && obs_a[1];
    a_in_valid = sent; a_in_data = d; a_in_error = 1'b0;
    a_in_sop = sop; a_in_eop = eop; a_in_empty = eop ? 3'($urandom) : 3'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    tick(); tick();
    checks++;
    if (act_a !== exp_a() || act_a !== 89'd0) begin
      failures++; $display("FAIL reset_a got=%h exp=%h", act_a, exp_a());
    end
    checks++;
    if (act_b !== exp_b() || act_b !== 89'd0) begin
      failures++; $display("FAIL reset_b got=%h exp=%h", act_b, exp_b());
    end
    reset = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%b%b exp=11", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_streaming();
    int sent_n = 0, got_n = 0;
    logic s;
    a_out_ready = 1'b1;
    for (int cyc = 0; cyc < 110; cyc++) begin
      drive_a(sent_n < 100, 64'(sent_n), sent_n == 0, sent_n == 99, s);
      if (a_out_valid) begin
        checks++;
        if (a_out_data !== 64'(got_n)) begin
          failures++; $display("FAIL stream_order got=%0d exp=%0d", a_out_data, got_n);
        end
        got_n++;
      end
      tick();
      if (s) sent_n++;
      checks++;
      if (act_a !== exp_a() || a_in_ready !== 1'b1) begin
        failures++; $display("FAIL streaming cyc=%0d got=%h exp=%h", cyc, act_a, exp_a());
      end
    end
    drive_a(1'b0, '0, 1'b0, 1'b0, s);
    checks++;
    if (got_n != 100 || a_drop !== 16'd0) begin
      failures++; $display("FAIL stream_count got=%0d/%0d exp=100/0", got_n, a_drop);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0, drained = 0;
    logic s;
    a_out_ready = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      drive_a(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, s);
      tick();
      if (s) acc++;
      checks++;
      if (act_a !== exp_a()) begin
        failures++; $display("FAIL bp_fill cyc=%0d got=%h exp=%h", cyc, act_a, exp_a());
      end
    end
    drive_a(1'b0, '0, 1'b0, 1'b0, s);
    checks++;
    if (acc != 8 || a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin
      failures++; $display("FAIL bp_full got=%0d,%b,%b exp=8,0,1", acc, a_in_ready, a_out_valid);
    end
    a_out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (a_out_valid) drained++;
      tick();
      checks++;
      if (act_a !== exp_a()) begin
        failures++; $display("FAIL bp_drain cyc=%0d got=%h exp=%h", cyc, act_a, exp_a());
      end
    end
    checks++;
    if (drained != 8 || a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty got=%0d,%b,%b exp=8,1,0", drained, a_in_ready, a_out_valid);
    end
  endtask

  task automatic test_violation();
    int n = 0, k = 0;
    logic s;
    logic eop_err[$];
    a_out_ready = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      drive_a(1'b1, 64'h1000 + 64'(n), n == 0, 1'b0, s);
      tick();
      if (s) n++;
      checks++;
      if (act_a !== exp_a()) begin
        failures++; $display("FAIL viol_fill cyc=%0d got=%h exp=%h", cyc, act_a, exp_a());
      end
    end
    a_in_valid = 1'b1; a_in_data = 64'hDEAD; a_in_sop = 1'b0; a_in_eop = 1'b0;
    tick();
    checks++;
    if (act_a !== exp_a()) begin
      failures++; $display("FAIL viol_drop got=%h exp=%h", act_a, exp_a());
    end
    a_out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      drive_a(k < 5, 64'h2000 + 64'(k), k == 2, k == 1 || k == 4, s);
      if (a_out_valid) begin
        checks++;
        if (a_out_data === 64'hDEAD) begin
          failures++; $display("FAIL viol_dropped_seen got=%h exp=absent", a_out_data);
        end
        if (a_out_eop) eop_err.push_back(a_out_error);
      end
      tick();
      if (s) k++;
      checks++;
      if (act_a !== exp_a()) begin
        failures++; $display("FAIL viol_tail cyc=%0d got=%h exp=%h", cyc, act_a, exp_a());
      end
    end
    drive_a(1'b0, '0, 1'b0, 1'b0, s);
    checks++;
    if (a_drop !== 16'd1 || a_ovf !== 1'b1 || eop_err.size() != 2) begin
      failures++;
      $display("FAIL viol_count got=%0d,%b,%0d exp=1,1,2", a_drop, a_ovf, eop_err.size());
    end else begin
      checks++;
      if (eop_err[0] !== 1'b1 || eop_err[1] !== 1'b0) begin
        failures++; $display("FAIL viol_eop_err got=%b%b exp=10", eop_err[0], eop_err[1]);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic s;
    for (int cyc = 0; cyc < 400; cyc++) begin
      a_out_ready = (cyc < 200) ? ($urandom % 4 == 0) : 1'($urandom % 2);
      drive_a($urandom % 4 != 0, {$urandom, $urandom}, $urandom % 5 == 0, $urandom % 5 == 0, s);
      tick();
      checks++;
      if (act_a !== exp_a() || a_drop !== 16'd1) begin
        failures++; $display("FAIL simul_a cyc=%0d got=%h exp=%h", cyc, act_a, exp_a());
      end
    end
    drive_a(1'b0, '0, 1'b0, 1'b0, s);
    for (int cyc = 0; cyc < 300; cyc++) begin
      b_out_ready = 1'($urandom % 2);
      b_in_data = {$urandom, $urandom}; b_in_error = 1'($urandom % 8 == 0);
      b_in_sop = 1'($urandom % 4 == 0); b_in_eop = 1'($urandom % 4 == 0);
      b_in_empty = 3'($urandom);
      b_in_valid = ($urandom % 4 != 0) && b_in_ready;
      tick();
      checks++;
      if (act_b !== exp_b() || b_drop !== 16'd0) begin
        failures++; $display("FAIL simul_b cyc=%0d got=%h exp=%h", cyc, act_b, exp_b());
      end
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
  endtask

  task automatic test_saturation();
    logic s;
    a_out_ready = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      drive_a(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, s);
      tick();
    end
    for (int i = 0; i < 65540; i++) begin
      a_in_valid = 1'b1; a_in_data = {$urandom, $urandom};
      a_in_eop = 1'($urandom % 2); a_in_sop = 1'b0;
      tick();
      checks++;
      if (act_a !== exp_a()) begin
        failures++; $display("FAIL sat_step i=%0d got=%h exp=%h", i, act_a, exp_a());
      end
    end
    drive_a(1'b0, '0, 1'b0, 1'b0, s);
    checks++;
    if (a_drop !== 16'hFFFF || a_ovf !== 1'b1) begin
      failures++; $display("FAIL saturation got=%h,%b exp=ffff,1", a_drop, a_ovf);
    end
  endtask

  task automatic test_async_reset();
    int sent = 0, got = 0;
    logic s;
    a_out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) tick();
    a_out_ready = 1'b0;
    for (int cyc = 0; cyc < 30 && sent < 5; cyc++) begin
      drive_a(1'b1, {16'h5A5A, 48'(sent)}, sent == 0, 1'b0, s);
      tick();
      if (s) sent++;
    end
    drive_a(1'b0, '0, 1'b0, 1'b0, s);
    tick(); tick(); tick();
    checks++;
    if (act_a !== exp_a() || sent != 5) begin
      failures++; $display("FAIL arst_prefill got=%h exp=%h", act_a, exp_a());
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({a_out_valid, a_out_data, a_out_error, a_out_sop, a_out_eop, a_out_empty, a_in_ready,
         b_out_valid, b_in_ready} !== 74'd0) begin
      failures++; $display("FAIL arst_immediate got=%b,%h exp=0,0", a_out_valid, a_out_data);
    end
    model_reset();
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 1'b1 || a_drop !== 16'd0 || a_ovf !== 1'b0 || a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL arst_release got=%b,%h,%b,%b exp=1,0,0,0", a_in_ready, a_drop, a_ovf,
               a_out_valid);
    end
    a_out_ready = 1'b1;
    sent = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      drive_a(sent < 8, {16'hA5A5, 48'(sent)}, sent == 0, sent == 7, s);
      if (a_out_valid) begin
        checks++;
        if (a_out_data[63:48] !== 16'hA5A5) begin
          failures++; $display("FAIL arst_stale got=%h exp=a5a5xxxx", a_out_data);
        end
        got++;
      end
      tick();
      if (s) sent++;
      checks++;
      if (act_a !== exp_a()) begin
        failures++; $display("FAIL arst_stream cyc=%0d got=%h exp=%h", cyc, act_a, exp_a());
      end
    end
    checks++;
    if (got != 8) begin
      failures++; $display("FAIL arst_count got=%0d exp=8", got);
    end
  endtask

  initial begin
    a_in_valid = 0; a_in_data = '0; a_in_error = 0; a_in_sop = 0; a_in_eop = 0;
    a_in_empty = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_data = '0; b_in_error = 0; b_in_sop = 0; b_in_eop = 0;
    b_in_empty = '0; b_out_ready = 1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_violation();
    test_simultaneous();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
